// File: rtl/display_pkg.sv
// Shared constants and scheduler state encoding for the register-view display path.
package display_pkg;

  localparam int unsigned NUM_REGS = 26;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [1:0] {
    SEL  = 2'd0,
    CAP  = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchroniser, stable-sample debouncer and
// a single-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             settled;

  // cnt holds how many consecutive samples so far disagree with level
  assign settled = (cnt == CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync       <= {sync[0], btn_raw};
      rise_pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (settled) begin
        level      <= sync[1];
        cnt        <= '0;
        rise_pulse <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reg_view_scheduler.sv
// Chooses which CPU register is shown: drives the external register mux select and
// captures the returned value for the seven-segment displays (auto or button stepping).
module reg_view_scheduler #(
  parameter int unsigned NUM_REGS   = display_pkg::NUM_REGS,
  parameter int unsigned DWELL      = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned IDX_W      = display_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             btn_mode,
  input  logic [31:0]      reg_data,
  output logic [IDX_W-1:0] reg_sel,
  output logic [31:0]      disp_value,
  output logic [IDX_W-1:0] disp_idx,
  output logic             auto_mode,
  output logic             new_sel
);

  import display_pkg::*;

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  sched_state_t     state, state_nxt;
  logic [IDX_W-1:0] reg_sel_nxt, disp_idx_nxt, sel_inc, sel_dec;
  logic [31:0]      disp_value_nxt;
  logic             auto_nxt, new_sel_nxt;
  logic [DW_W-1:0]  dwell_cnt, dwell_nxt;
  logic             nxt_p, prv_p, mod_p;
  // debounced levels are not consumed here, only their rising-edge pulses
  logic [2:0]       lvl_unused;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk), .rst(rst), .btn_raw(btn_next), .level(lvl_unused[0]), .rise_pulse(nxt_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk(clk), .rst(rst), .btn_raw(btn_prev), .level(lvl_unused[1]), .rise_pulse(prv_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .rst(rst), .btn_raw(btn_mode), .level(lvl_unused[2]), .rise_pulse(mod_p)
  );

  // Wrapping index neighbours; reg_sel stays within 0..NUM_REGS-1
  assign sel_inc = (reg_sel == IDX_W'(NUM_REGS - 1)) ? '0 : reg_sel + IDX_W'(1);
  assign sel_dec = (reg_sel == '0) ? IDX_W'(NUM_REGS - 1) : reg_sel - IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEL;
      reg_sel    <= '0;
      disp_value <= '0;
      disp_idx   <= '0;
      auto_mode  <= 1'b1;
      new_sel    <= 1'b0;
      dwell_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      reg_sel    <= reg_sel_nxt;
      disp_value <= disp_value_nxt;
      disp_idx   <= disp_idx_nxt;
      auto_mode  <= auto_nxt;
      new_sel    <= new_sel_nxt;
      dwell_cnt  <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    reg_sel_nxt    = reg_sel;
    disp_value_nxt = disp_value;
    disp_idx_nxt   = disp_idx;
    auto_nxt       = auto_mode;
    new_sel_nxt    = 1'b0;
    dwell_nxt      = dwell_cnt;

    case (state)
      SEL: state_nxt = CAP;
      CAP: begin
        disp_value_nxt = reg_data;
        disp_idx_nxt   = reg_sel;
        new_sel_nxt    = 1'b1;
        dwell_nxt      = '0;
        state_nxt      = HOLD;
      end
      HOLD: begin
        disp_value_nxt = reg_data;
        // simultaneous next+prev cancel each other out
        if (nxt_p && prv_p) begin
          state_nxt = HOLD;
        end else if (nxt_p) begin
          reg_sel_nxt = sel_inc;
          state_nxt   = SEL;
        end else if (prv_p) begin
          reg_sel_nxt = sel_dec;
          state_nxt   = SEL;
        end else if (auto_mode && (dwell_cnt == DW_W'(DWELL - 1))) begin
          reg_sel_nxt = sel_inc;
          state_nxt   = SEL;
        end else if (auto_mode) begin
          dwell_nxt = dwell_cnt + DW_W'(1);
        end
      end
      default: state_nxt = SEL;
    endcase

    // mode toggles are honoured in every state
    if (mod_p) begin
      auto_nxt  = ~auto_mode;
      dwell_nxt = '0;
    end
  end

endmodule

// File: tb/tb_reg_view_scheduler.sv
// Randomised and directed bench for reg_view_scheduler against a behavioural model
// of button acceptance, index stepping and display capture.
module tb_reg_view_scheduler;

  localparam int NR    = 26;
  localparam int DWELL = 4;
  localparam int DEB   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next, btn_prev, btn_mode;
  logic [31:0] reg_data;
  logic [4:0]  reg_sel, disp_idx;
  logic [31:0] disp_value;
  logic        auto_mode, new_sel;

  logic [31:0] regfile [32];

  int checks = 0;
  int errors = 0;
  int ns_count = 0;
  bit chk_en = 1'b0;

  // model state
  int          m_sel, m_shown, m_wait, m_dwell;
  logic [31:0] m_val;
  bit          m_auto, m_new;
  bit [DEB+1:0] hist [3];
  bit          lvl [3];
  bit          pls [3];

  reg_view_scheduler #(
    .NUM_REGS(NR), .DWELL(DWELL), .DEB_CYCLES(DEB), .IDX_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_mode(btn_mode),
    .reg_data(reg_data), .reg_sel(reg_sel),
    .disp_value(disp_value), .disp_idx(disp_idx),
    .auto_mode(auto_mode), .new_sel(new_sel)
  );

  always #5 clk = ~clk;

  // external register mux
  assign reg_data = regfile[reg_sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock edge of the reference: buttons accepted after DEB stable synchronised
  // samples, a capture two edges after any index change, dwell counted in HOLD.
  task automatic model_step();
    bit raw [3];
    bit use_n, use_p, use_m, all_hi, all_lo;
    raw[0] = btn_next; raw[1] = btn_prev; raw[2] = btn_mode;
    if (rst) begin
      m_sel = 0; m_shown = 0; m_val = '0; m_auto = 1'b1; m_new = 1'b0;
      m_wait = 2; m_dwell = 0;
      for (int b = 0; b < 3; b++) begin
        hist[b] = '0; lvl[b] = 1'b0; pls[b] = 1'b0;
      end
      chk_en = 1'b1;
      return;
    end
    use_n = pls[0]; use_p = pls[1]; use_m = pls[2];
    m_new = 1'b0;
    if (m_wait == 2) begin
      m_wait = 1;
    end else if (m_wait == 1) begin
      m_val = regfile[m_sel]; m_shown = m_sel; m_new = 1'b1; m_dwell = 0; m_wait = 0;
    end else begin
      m_val = regfile[m_sel];
      if (use_n && use_p) begin
        m_wait = 0;
      end else if (use_n || (!use_p && m_auto && m_dwell == DWELL - 1)) begin
        m_sel = (m_sel + 1) % NR; m_wait = 2;
      end else if (use_p) begin
        m_sel = (m_sel + NR - 1) % NR; m_wait = 2;
      end else if (m_auto) begin
        m_dwell++;
      end
    end
    if (use_m) begin
      m_auto = !m_auto; m_dwell = 0;
    end
    for (int b = 0; b < 3; b++) begin
      hist[b] = {hist[b][DEB:0], raw[b]};
      all_hi = 1'b1; all_lo = 1'b1;
      for (int j = 2; j < DEB + 2; j++) begin
        if (hist[b][j]) all_lo = 1'b0;
        else all_hi = 1'b0;
      end
      pls[b] = 1'b0;
      if (!lvl[b] && all_hi) begin
        lvl[b] = 1'b1; pls[b] = 1'b1;
      end else if (lvl[b] && all_lo) begin
        lvl[b] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (chk_en) begin
      check("reg_sel", 32'(reg_sel), 32'(m_sel));
      check("disp_idx", 32'(disp_idx), 32'(m_shown));
      check("disp_value", disp_value, m_val);
      check("auto_mode", 32'(auto_mode), 32'(m_auto));
      check("new_sel", 32'(new_sel), 32'(m_new));
    end
  end

  always @(posedge clk) begin
    #1;
    if (new_sel === 1'b1) ns_count++;
  end

  task automatic press(input bit n, input bit p, input bit m);
    btn_next = n; btn_prev = p; btn_mode = m;
    repeat (6) @(negedge clk);
    btn_next = 1'b0; btn_prev = 1'b0; btn_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int idx0, ns0;
    int hold [3];
    rst = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; btn_mode = 1'b0;
    for (int i = 0; i < 32; i++) regfile[i] = 32'hA5;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: first capture two edges after reset, next one DWELL+2 later
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_new_sel", 32'(new_sel), 32'd1);
    check("t1_disp_idx", 32'(disp_idx), 32'd0);
    check("t1_disp_value", disp_value, 32'hA5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t1_gap_quiet", 32'(new_sel), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t1_second_pulse", 32'(new_sel), 32'd1);
    check("t1_reg_sel", 32'(reg_sel), 32'd1);
    check("t1_disp_idx2", 32'(disp_idx), 32'd1);

    // 2: auto wrap from 25 back to 0
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (new_sel && disp_idx == 5'd25) ok = 1'b1;
    end
    check("t2_reach25", 32'(ok), 32'd1);
    repeat (6) @(negedge clk);
    check("t2_wrap_new_sel", 32'(new_sel), 32'd1);
    check("t2_wrap_disp_idx", 32'(disp_idx), 32'd0);
    check("t2_wrap_reg_sel", 32'(reg_sel), 32'd0);

    // 3: short mode glitch ignored, real press toggles once, manual index frozen
    btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_glitch", 32'(auto_mode), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("t3_toggle", 32'(auto_mode), 32'd0);
    idx0 = int'(disp_idx);
    repeat (100) @(negedge clk);
    check("t3_frozen_idx", 32'(disp_idx), 32'(idx0));
    check("t3_frozen_sel", 32'(reg_sel), 32'(idx0));
    check("t3_still_manual", 32'(auto_mode), 32'd0);

    // 4: manual wrap in both directions, simultaneous presses cancel
    for (int i = 0; i < 30 && disp_idx != 5'd0; i++) press(1'b0, 1'b1, 1'b0);
    check("t4_at0", 32'(disp_idx), 32'd0);
    press(1'b0, 1'b1, 1'b0);
    check("t4_prev_wrap", 32'(disp_idx), 32'd25);
    press(1'b1, 1'b0, 1'b0);
    check("t4_next_wrap", 32'(disp_idx), 32'd0);
    ns0 = ns_count;
    press(1'b1, 1'b1, 1'b0);
    check("t4_both_idx", 32'(disp_idx), 32'd0);
    check("t4_both_no_new_sel", 32'(ns_count), 32'(ns0));

    // 5: live view while holding
    regfile[0] = 32'd1;
    repeat (2) @(negedge clk);
    check("t5_live1", disp_value, 32'd1);
    regfile[0] = 32'd2;
    @(negedge clk);
    check("t5_live2", disp_value, 32'd2);
    check("t5_no_new_sel", 32'(new_sel), 32'd0);

    // 6: reset mid-operation with next held
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b0);
    check("t6_at7", 32'(disp_idx), 32'd7);
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_sel", 32'(reg_sel), 32'd0);
    check("t6_rst_idx", 32'(disp_idx), 32'd0);
    check("t6_rst_value", disp_value, 32'd0);
    check("t6_rst_auto", 32'(auto_mode), 32'd1);
    check("t6_rst_new_sel", 32'(new_sel), 32'd0);
    repeat (4) @(negedge clk);
    check("t6_no_early_step", 32'(reg_sel), 32'd0);
    repeat (3) @(negedge clk);
    check("t6_held_step", 32'(reg_sel), 32'd1);
    btn_next = 1'b0;

    // random phase: buttons with random hold times, register writes, rare resets
    for (int b = 0; b < 3; b++) hold[b] = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          hold[b] = $urandom_range(1, 8);
          case (b)
            0: btn_next = 1'($urandom_range(0, 1));
            1: btn_prev = 1'($urandom_range(0, 1));
            default: btn_mode = 1'($urandom_range(0, 3) == 0);
          endcase
        end else begin
          hold[b]--;
        end
      end
      if ($urandom_range(0, 3) == 0) regfile[$urandom_range(0, NR - 1)] = $urandom;
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
